// File: rtl/lamp_i2f_pipe.sv
// lamp_i2f_pipe: integer to packed float converter with internal rounding (RNE/RTZ/RDN/RUP).
// Latency: 3 cycles from acceptance to out_valid_o, throughput 1 per cycle, strictly in order.
// Backpressure: one global advance (~out_valid_o | out_ready_i); when it is low every stage holds.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid_i/in_ready_o  operand handshake; op_i, signed_i, rnd_mode_i travel with it
//   out_valid_o/out_ready_i result handshake; res_o = {sign, exp, fract}, inexact_o, overflow_o
//   tag_i/tag_o            sideband tag, present only when LAMP_I2F_TAG_EN is defined
// Optional build macro: LAMP_I2F_TAG_EN
module lamp_i2f_pipe #(
  parameter int INT_DW = 32,
  parameter int E_DW   = 8,
  parameter int F_DW   = 7,
  parameter int E_BIAS = 2**(E_DW-1)-1,
  parameter int TAG_DW = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [INT_DW-1:0]    op_i,
  input  logic                 signed_i,
  input  logic [1:0]           rnd_mode_i,
`ifdef LAMP_I2F_TAG_EN
  input  logic [TAG_DW-1:0]    tag_i,
  output logic [TAG_DW-1:0]    tag_o,
`endif
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [E_DW+F_DW:0]   res_o,
  output logic                 inexact_o,
  output logic                 overflow_o
);

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RTZ = 2'b01;
  localparam logic [1:0] RM_RDN = 2'b10;
  localparam logic [1:0] RM_RUP = 2'b11;

  localparam int LZW = $clog2(INT_DW) + 1;
  // exponent arithmetic width: room for unbiased exponent + bias + carry without wrapping
  localparam int XW  = ((E_DW > LZW) ? E_DW : LZW) + 2;
  // bits below the hidden one, padded so fraction/guard/sticky always exist
  localparam int NW  = INT_DW + F_DW + 1;

  localparam logic [XW-1:0] EXP_INF = XW'((1 << E_DW) - 1);
  localparam logic [XW-1:0] BIAS    = XW'(E_BIAS);

  if (INT_DW < 2 || TAG_DW < 1) begin : gParamCheck
    $error("lamp_i2f_pipe: INT_DW must be >= 2 and TAG_DW >= 1");
  end

  logic adv;
  assign adv        = ~out_valid_o | out_ready_i;
  assign in_ready_o = adv;

  // ---------------- S1: sign / magnitude ----------------
  logic              opNeg;
  logic [INT_DW-1:0] opMag;
  assign opNeg = signed_i & op_i[INT_DW-1];
  // negating the most negative value wraps to itself, which read unsigned is 2^(INT_DW-1)
  assign opMag = opNeg ? (-op_i) : op_i;

  logic              s1Vld, s1Sign, s1Zero;
  logic [INT_DW-1:0] s1Mag;
  logic [1:0]        s1Rnd;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1Vld  <= 1'b0;
      s1Sign <= 1'b0;
      s1Zero <= 1'b0;
      s1Mag  <= '0;
      s1Rnd  <= '0;
    end else if (adv) begin
      s1Vld  <= in_valid_i;
      s1Sign <= opNeg;
      s1Zero <= (op_i == '0);
      s1Mag  <= opMag;
      s1Rnd  <= rnd_mode_i;
    end
  end

  // ---------------- S2: normalise ----------------
  logic [LZW-1:0]    lz;
  logic [INT_DW-1:0] shifted;
  logic [NW-1:0]     normExt;
  logic [F_DW-1:0]   nFract;
  logic              nGuard, nSticky, hidden;
  logic [LZW-1:0]    eUnb;

  always_comb begin
    lz = '0;
    // highest set bit wins because it is visited last
    for (int i = 0; i < INT_DW; i++) begin
      if (s1Mag[i]) lz = LZW'(INT_DW - 1 - i);
    end
  end

  assign shifted = s1Mag << lz;
  assign hidden  = shifted[INT_DW-1];
  assign normExt = {shifted[INT_DW-2:0], {(F_DW+2){1'b0}}};
  assign nFract  = normExt[NW-1 -: F_DW];
  assign nGuard  = normExt[NW-1-F_DW];
  assign nSticky = |normExt[NW-2-F_DW:0];
  assign eUnb    = LZW'(INT_DW - 1) - lz;

  logic            s2Vld, s2Sign, s2Zero, s2Guard, s2Sticky;
  logic [1:0]      s2Rnd;
  logic [LZW-1:0]  s2Exp;
  logic [F_DW-1:0] s2Fract;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2Vld    <= 1'b0;
      s2Sign   <= 1'b0;
      s2Zero   <= 1'b0;
      s2Guard  <= 1'b0;
      s2Sticky <= 1'b0;
      s2Rnd    <= '0;
      s2Exp    <= '0;
      s2Fract  <= '0;
    end else if (adv) begin
      s2Vld    <= s1Vld;
      s2Sign   <= s1Sign;
      // the hidden bit is only clear for a zero magnitude
      s2Zero   <= s1Zero | ~hidden;
      s2Guard  <= nGuard;
      s2Sticky <= nSticky;
      s2Rnd    <= s1Rnd;
      s2Exp    <= eUnb;
      s2Fract  <= nFract;
    end
  end

  // ---------------- S3: round / pack ----------------
  logic            inc, carry, ovf, toInf, inexact;
  logic [F_DW:0]   mantInc;
  logic [XW-1:0]   expB;
  logic [E_DW+F_DW:0] resN;

  always_comb begin
    inc = 1'b0;
    case (s2Rnd)
      RM_RNE:  inc = s2Guard & (s2Sticky | s2Fract[0]);
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = s2Sign & (s2Guard | s2Sticky);
      RM_RUP:  inc = ~s2Sign & (s2Guard | s2Sticky);
      default: inc = 1'b0;
    endcase
  end

  // a carry out leaves the fraction field all zeros, so it can be used as-is
  assign mantInc = {1'b0, s2Fract} + (F_DW+1)'(inc);
  assign carry   = mantInc[F_DW];
  assign expB    = XW'(s2Exp) + BIAS + XW'(carry);
  assign ovf     = (expB >= EXP_INF);
  assign toInf   = (s2Rnd == RM_RNE) | ((s2Rnd == RM_RUP) & ~s2Sign) | ((s2Rnd == RM_RDN) & s2Sign);
  assign inexact = s2Guard | s2Sticky | ovf;

  always_comb begin
    resN = '0;
    if (s2Zero) begin
      resN = '0;
    end else if (ovf) begin
      if (toInf) resN = {s2Sign, {E_DW{1'b1}}, {F_DW{1'b0}}};
      else       resN = {s2Sign, {(E_DW-1){1'b1}}, 1'b0, {F_DW{1'b1}}};
    end else begin
      resN = {s2Sign, expB[E_DW-1:0], mantInc[F_DW-1:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_o <= 1'b0;
      res_o       <= '0;
      inexact_o   <= 1'b0;
      overflow_o  <= 1'b0;
    end else if (adv) begin
      out_valid_o <= s2Vld;
      res_o       <= resN;
      inexact_o   <= ~s2Zero & inexact;
      overflow_o  <= ~s2Zero & ovf;
    end
  end

`ifdef LAMP_I2F_TAG_EN
  logic [TAG_DW-1:0] s1Tag, s2Tag;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1Tag <= '0;
      s2Tag <= '0;
      tag_o <= '0;
    end else if (adv) begin
      s1Tag <= tag_i;
      s2Tag <= s1Tag;
      tag_o <= s2Tag;
    end
  end
`endif

endmodule

// File: tb/tb_lamp_i2f_pipe.sv
module tb_lamp_i2f_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // default-format instance (bfloat16)
  logic        aInVld, aInRdy, aSgn, aOutVld, aOutRdy, aInx, aOvf;
  logic [31:0] aOp;
  logic [1:0]  aRnd;
  logic [15:0] aRes;
  // half-precision-shaped instance for overflow cases
  logic        hInVld, hInRdy, hSgn, hOutVld, hOutRdy, hInx, hOvf;
  logic [31:0] hOp;
  logic [1:0]  hRnd;
  logic [15:0] hRes;
`ifdef LAMP_I2F_TAG_EN
  logic [3:0]  aTagI, aTagO, hTagI, hTagO;
`endif

  lamp_i2f_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid_i(aInVld), .in_ready_o(aInRdy),
    .op_i(aOp), .signed_i(aSgn), .rnd_mode_i(aRnd),
`ifdef LAMP_I2F_TAG_EN
    .tag_i(aTagI), .tag_o(aTagO),
`endif
    .out_valid_o(aOutVld), .out_ready_i(aOutRdy),
    .res_o(aRes), .inexact_o(aInx), .overflow_o(aOvf)
  );

  lamp_i2f_pipe #(.E_DW(5), .F_DW(10)) dutH (
    .clk(clk), .rst(rst),
    .in_valid_i(hInVld), .in_ready_o(hInRdy),
    .op_i(hOp), .signed_i(hSgn), .rnd_mode_i(hRnd),
`ifdef LAMP_I2F_TAG_EN
    .tag_i(hTagI), .tag_o(hTagO),
`endif
    .out_valid_o(hOutVld), .out_ready_i(hOutRdy),
    .res_o(hRes), .inexact_o(hInx), .overflow_o(hOvf)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] op;
    logic        sgn;
    logic [1:0]  rnd;
    logic        half;
    logic [15:0] res;
    logic        inx;
    logic        ovf;
  } vec_t;

  vec_t vecs[18];
  int   nVec;

  task automatic runVec(input int idx);
    vec_t v;
    int   lat;
    bit   seen;
    v = vecs[idx];
    @(negedge clk);
    if (!v.half) begin
      aInVld = 1'b1; aOp = v.op; aSgn = v.sgn; aRnd = v.rnd;
    end else begin
      hInVld = 1'b1; hOp = v.op; hSgn = v.sgn; hRnd = v.rnd;
    end
    seen = 1'b0;
    @(posedge clk);
    lat = 1;
    #1;
    aInVld = 1'b0;
    hInVld = 1'b0;
    while (!seen && lat < 10) begin
      @(negedge clk);
      if (v.half ? hOutVld : aOutVld) seen = 1'b1;
      else begin
        @(posedge clk);
        lat++;
      end
    end
    check($sformatf("v%0d_seen", idx), {31'b0, seen}, 32'd1);
    check($sformatf("v%0d_latency", idx), lat, 32'd3);
    check($sformatf("v%0d_res", idx), {16'b0, (v.half ? hRes : aRes)}, {16'b0, v.res});
    check($sformatf("v%0d_inexact", idx), {31'b0, (v.half ? hInx : aInx)}, {31'b0, v.inx});
    check($sformatf("v%0d_overflow", idx), {31'b0, (v.half ? hOvf : aOvf)}, {31'b0, v.ovf});
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] bpExp[6];
    int issued, got, dropAt, extra;

    // {op, signed, rnd, half-instance, res, inexact, overflow}
    vecs[0]  = '{32'd1,        1'b1, 2'd0, 1'b0, 16'h3F80, 1'b0, 1'b0};
    vecs[1]  = '{32'hFFFFFFFF, 1'b1, 2'd0, 1'b0, 16'hBF80, 1'b0, 1'b0};
    vecs[2]  = '{32'd0,        1'b1, 2'd0, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[3]  = '{32'd257,      1'b1, 2'd0, 1'b0, 16'h4380, 1'b1, 1'b0};
    vecs[4]  = '{32'd259,      1'b1, 2'd0, 1'b0, 16'h4382, 1'b1, 1'b0};
    vecs[5]  = '{32'd259,      1'b1, 2'd1, 1'b0, 16'h4381, 1'b1, 1'b0};
    vecs[6]  = '{32'hFFFFFEFD, 1'b1, 2'd2, 1'b0, 16'hC382, 1'b1, 1'b0};
    vecs[7]  = '{32'h80000000, 1'b1, 2'd0, 1'b0, 16'hCF00, 1'b0, 1'b0};
    vecs[8]  = '{32'hFFFFFFFF, 1'b0, 2'd0, 1'b0, 16'h4F80, 1'b1, 1'b0};
    vecs[9]  = '{32'hFFFFFFFF, 1'b1, 2'd0, 1'b0, 16'hBF80, 1'b0, 1'b0};
    vecs[10] = '{32'd0,        1'b1, 2'd3, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[11] = '{32'd70000,    1'b0, 2'd0, 1'b1, 16'h7C00, 1'b1, 1'b1};
    vecs[12] = '{32'd65520,    1'b0, 2'd0, 1'b1, 16'h7C00, 1'b1, 1'b1};
    vecs[13] = '{32'd70000,    1'b0, 2'd1, 1'b1, 16'h7BFF, 1'b1, 1'b1};
    vecs[14] = '{32'hFFFEEE90, 1'b1, 2'd2, 1'b1, 16'hFC00, 1'b1, 1'b1};  // -70000 RDN
    vecs[15] = '{32'hFFFEEE90, 1'b1, 2'd3, 1'b1, 16'hFBFF, 1'b1, 1'b1};  // -70000 RUP
    vecs[16] = '{32'd65504,    1'b0, 2'd0, 1'b1, 16'h7BFF, 1'b0, 1'b0};
    vecs[17] = '{32'd7,        1'b1, 2'd3, 1'b1, 16'h4700, 1'b0, 1'b0};
    nVec = 18;

    bpExp[0] = 16'h3F80; bpExp[1] = 16'h4000; bpExp[2] = 16'h4040;
    bpExp[3] = 16'h4080; bpExp[4] = 16'h40A0; bpExp[5] = 16'h40C0;

    rst = 1'b1;
    aInVld = 1'b0; aOp = '0; aSgn = 1'b0; aRnd = '0; aOutRdy = 1'b1;
    hInVld = 1'b0; hOp = '0; hSgn = 1'b0; hRnd = '0; hOutRdy = 1'b1;
`ifdef LAMP_I2F_TAG_EN
    aTagI = '0; hTagI = '0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", {31'b0, aOutVld}, 32'd0);
    check("rst_res", {16'b0, aRes}, 32'd0);
    check("rst_inexact", {31'b0, aInx}, 32'd0);
    check("rst_overflow", {31'b0, aOvf}, 32'd0);
    check("rst_in_ready", {31'b0, aInRdy}, 32'd1);
    check("rst_h_out_valid", {31'b0, hOutVld}, 32'd0);
`ifdef LAMP_I2F_TAG_EN
    check("rst_tag", {28'b0, aTagO}, 32'd0);
`endif

    for (int i = 0; i < nVec; i++) runVec(i);

    // backpressure: six back-to-back operands, sink stalled for the first 5 cycles
    issued = 0; got = 0; dropAt = -1;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      @(negedge clk);
      aOutRdy = (cyc >= 5);
      aInVld  = (issued < 6);
      aOp     = 32'(issued + 1);
      aSgn    = 1'b0;
      aRnd    = 2'd0;
`ifdef LAMP_I2F_TAG_EN
      aTagI   = 4'(issued + 3);
`endif
      #1;
      if (!aInRdy && dropAt < 0) dropAt = issued;
      if (cyc == 4) check("bp_hold_res", {16'b0, aRes}, 32'h3F80);
      if (aOutVld && aOutRdy) begin
        check($sformatf("bp_res%0d", got), {16'b0, aRes}, {16'b0, bpExp[got]});
`ifdef LAMP_I2F_TAG_EN
        check($sformatf("bp_tag%0d", got), {28'b0, aTagO}, 32'(4'(got + 3)));
`endif
        got++;
      end
      if (aInVld && aInRdy) issued++;
    end
    @(negedge clk);
    aInVld = 1'b0;
    aOutRdy = 1'b1;
    check("bp_in_ready_drop_after", dropAt, 32'd3);
    check("bp_results_count", got, 32'd6);
    check("bp_issued_count", issued, 32'd6);
    extra = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (aOutVld) extra++;
    end
    check("bp_no_duplicates", extra, 32'd0);

    // reset with two operands in flight
    @(negedge clk);
    aInVld = 1'b1; aOp = 32'd7; aSgn = 1'b0; aRnd = 2'd0;
    @(negedge clk);
    aOp = 32'd8;
    @(negedge clk);
    aInVld = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", {31'b0, aOutVld}, 32'd0);
    check("midrst_res", {16'b0, aRes}, 32'd0);
    rst = 1'b0;
    extra = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (aOutVld) extra++;
    end
    check("midrst_nothing_emitted", extra, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lamp_i2f_pipe.md
Name: lamp_i2f_pipe

Overview:
- Parametrised, pipelined integer-to-float converter for the lampFPU bfloat16 datapath and future FP formats.
- Accepts signed or unsigned integers of configurable width and performs the rounding internally; the core rounding stage is not needed.
- Emits a packed IEEE-style result with exception flags.
- Uses a 3-stage pipeline with valid/ready backpressure on both sides.

Parameters:
- INT_DW, 32, integer operand width (≥2).
- E_DW, 8, exponent field width.
- F_DW, 7, stored fraction width.
- E_BIAS, 2**(E_DW-1)-1, exponent bias.
- TAG_DW, 4, width of the sideband tag. Used only when LAMP_I2F_TAG_EN is defined.

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- in_valid_i  in  1  operand valid
- in_ready_o  out  1  converter can accept an operand this cycle
- op_i  in  INT_DW  integer operand
- signed_i  in  1  1 = two's-complement operand, 0 = unsigned operand
- rnd_mode_i  in  2  rounding mode: 00 RNE, 01 RTZ, 10 RDN (toward −inf), 11 RUP (toward +inf)
- tag_i  in  TAG_DW  sideband tag (only with LAMP_I2F_TAG_EN)
- out_valid_o  out  1  result valid
- out_ready_i  in  1  downstream accepts the result
- res_o  out  1+E_DW+F_DW  packed {sign, exp, fract}
- inexact_o  out  1  result differs from the exact integer value
- overflow_o  out  1  magnitude exceeds the largest finite value
- tag_o  out  TAG_DW  tag aligned with res_o (only with LAMP_I2F_TAG_EN)

Behaviour:
- Reset:
  - All stage valids clear; out_valid_o=0.
  - res_o, inexact_o, overflow_o and tag_o are 0.
  - in_ready_o=1 in the first cycle after reset.
  - Reset mid-operation discards every in-flight operand; nothing is emitted afterwards.
- Pipeline control:
  - Single global advance: adv = ~out_valid_o | out_ready_i.
  - in_ready_o = adv. An operand is accepted when in_valid_i & in_ready_o.
  - When adv=1, all stages shift by one; empty stages move as bubbles. Bubbles are not collapsed.
  - When adv=0, every stage register holds, including the outputs.
  - Latency is exactly 3 cycles from acceptance to out_valid_o, with no stalls.
  - Throughput is 1 result per cycle. Ordering is strictly in-order.
- S1 (sign/magnitude):
  - sign = signed_i & op_i[INT_DW-1].
  - mag = sign ? −op_i : op_i. mag is INT_DW bits wide; the most negative value maps correctly to 2^(INT_DW-1).
  - zero = (op_i==0). rnd_mode_i is registered with the operand.
- S2 (normalise):
  - lz = leading-zero count of mag.
  - Left-shift mag by lz so the MSB is 1.
  - e_unb = INT_DW−1−lz.
  - Extract F_DW fraction bits, a guard bit, and a sticky bit (OR of all remaining lower bits).
  - When INT_DW−1 ≤ F_DW, guard and sticky are 0.
- S3 (round/pack):
  - inc rules:
    - RNE: g & (s | lsb).
    - RTZ: 0.
    - RDN: sign & (g|s).
    - RUP: ~sign & (g|s).
  - Mantissa carry-out from inc increments the exponent and clears the fraction.
  - Biased exponent = e_unb + E_BIAS (+ carry).
  - If the biased exponent ≥ 2^E_DW−1, overflow_o=1 and inexact_o=1.
    - Result is ±inf for RNE.
    - Result is ±inf when the rounding direction is away from zero: RUP with positive sign, RDN with negative sign.
    - Otherwise the result is ±max finite (exp=2^E_DW−2, fract all ones).
  - inexact_o = g|s, or overflow.
  - A zero operand gives res_o=0 (+0, never −0) with both flags 0, regardless of mode.
  - Subnormal results cannot occur.
- in_valid_i asserted while in_ready_o=0 is ignored. The source must hold the operand until it is accepted.

Optional Feature:
- LAMP_I2F_TAG_EN: when defined, tag_i is captured on acceptance, travels through all 3 stages with the operand, and appears on tag_o alongside res_o.
- When undefined, tag_i and tag_o and their registers are absent.
- The datapath is identical in both builds.

Test Plan:
- Defaults, RNE, signed: inputs 1, −1, 0 → res_o 0x3F80, 0xBF80, 0x0000, all flags 0, each appearing 3 cycles after acceptance.
- Rounding: 257 RNE → 0x4380, inexact=1 (tie to even). 259 RNE → 0x4382. 259 RTZ → 0x4381. −259 RDN → 0xC382.
- Extremes: 0x80000000 signed → 0xCF00, exact. 0xFFFFFFFF unsigned RNE → 0x4F80, inexact. 0xFFFFFFFF signed → 0xBF80.
- Overflow with E_DW=5, F_DW=10: 70000 RNE → 0x7C00 with overflow=1 and inexact=1. 65520 RNE → 0x7C00 (carry-out path). 70000 RTZ → 0x7BFF.
- Backpressure: issue 6 back-to-back operands with out_ready_i=0 for 5 cycles → in_ready_o drops once 3 operands are held; all 6 results emerge in order with none lost or duplicated. With the tag build, tags match.
- Reset mid-flight: assert rst with 2 operands in the pipe → out_valid_o=0 the next cycle and nothing emitted afterwards.
